// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - register-bus initiator with credit-guarded FWFT read response FIFO
// REG_BUS_MASTER_BURST_EN: when defined, a read command issues max(iCMD_COUNT, 1) beats.
module reg_bus_master #(
  parameter int pADDRESS_BITS = 3,
  parameter int pREAD_LATENCY = 1,
  parameter int pRSP_DEPTH    = 4,
  parameter int pCOUNT_BITS   = 8
) (
  input  logic                     iCLOCK,
  input  logic                     iRESET,
  input  logic                     iCMD_VALID,
  output logic                     oCMD_READY,
  input  logic                     iCMD_WRITE,
  input  logic [pADDRESS_BITS-1:0] iCMD_ADDRESS,
  input  logic [31:0]              iCMD_DATA,
  input  logic [pCOUNT_BITS-1:0]   iCMD_COUNT,
  output logic                     oRSP_VALID,
  input  logic                     iRSP_READY,
  output logic [31:0]              oRSP_DATA,
  output logic [pADDRESS_BITS-1:0] oADDRESS,
  output logic                     oWRITE,
  output logic                     oREAD,
  output logic [31:0]              oWRITE_DATA,
  input  logic [31:0]              iREAD_DATA,
  output logic                     oBUSY
);

  localparam int PW = (pRSP_DEPTH > 1) ? $clog2(pRSP_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(pRSP_DEPTH);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                   state_q;
  logic [pCOUNT_BITS-1:0]   beats_left_q;
  logic [pCOUNT_BITS-1:0]   first_left;
  logic [pADDRESS_BITS-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic                     write_q, read_q, cmd_ready_q, busy_q;
  logic [pREAD_LATENCY-1:0] pipe_q;
  logic [CW-1:0]            inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]              mem_q [pRSP_DEPTH];
  logic                     rsp_valid_q;
  logic [31:0]              rsp_data_q, head_d;
  logic                     accept, has_credit, issue_rd, push, pop, credit_ok_d, pending_d;

`ifdef REG_BUS_MASTER_BURST_EN
  assign first_left = (iCMD_WRITE || iCMD_COUNT == '0) ? '0 : iCMD_COUNT - pCOUNT_BITS'(1);
`else
  logic unused_count;
  assign unused_count = ^iCMD_COUNT;
  assign first_left   = '0;
`endif

  // Credit = depth - occupancy - reads in flight; a push only moves a read between the two terms.
  always_comb begin
    accept      = (state_q == IDLE) && cmd_ready_q && iCMD_VALID;
    has_credit  = ((CW+1)'(count_q) + (CW+1)'(inflight_q)) < DEPTH_C;
    issue_rd    = accept ? !iCMD_WRITE
                         : ((state_q == ISSUE) && (beats_left_q != '0) && has_credit);
    push        = pipe_q[pREAD_LATENCY-1];
    pop         = rsp_valid_q && iRSP_READY;
    count_d     = count_q + CW'(push) - CW'(pop);
    inflight_d  = inflight_q + CW'(issue_rd) - CW'(push);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    head_d      = (push && (wr_ptr_q == rd_ptr_d)) ? iREAD_DATA : mem_q[rd_ptr_d];
    credit_ok_d = ((CW+1)'(count_d) + (CW+1)'(inflight_d)) < DEPTH_C;
    pending_d   = (count_d != '0) || (inflight_d != '0);
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= ISSUE;
            addr_q       <= iCMD_ADDRESS;
            if (iCMD_WRITE) wdata_q <= iCMD_DATA;
            write_q      <= iCMD_WRITE;
            read_q       <= !iCMD_WRITE;
            beats_left_q <= first_left;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
          end else begin
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            cmd_ready_q <= credit_ok_d;
            busy_q      <= pending_d;
          end
        end
        ISSUE: begin
          write_q <= 1'b0;
          if (beats_left_q == '0) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            cmd_ready_q <= credit_ok_d;
            busy_q      <= pending_d;
          end else begin
            read_q <= has_credit;
            if (has_credit) begin
              addr_q       <= addr_q + pADDRESS_BITS'(1);
              beats_left_q <= beats_left_q - pCOUNT_BITS'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      pipe_q      <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      pipe_q[0] <= read_q;
      for (int i = 1; i < pREAD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= (count_d != '0);
      if (count_d != '0) rsp_data_q <= head_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push) mem_q[wr_ptr_q] <= iREAD_DATA;
  end

  assign oCMD_READY  = cmd_ready_q;
  assign oRSP_VALID  = rsp_valid_q;
  assign oRSP_DATA   = rsp_data_q;
  assign oADDRESS    = addr_q;
  assign oWRITE      = write_q;
  assign oREAD       = read_q;
  assign oWRITE_DATA = wdata_q;
  assign oBUSY       = busy_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed and random checks of reg_bus_master against a queue model
// Expected beat counts follow REG_BUS_MASTER_BURST_EN so the bench covers both builds.
module tb_reg_bus_master;
  localparam int AW = 3;
  localparam int DEPTH = 4;
  localparam int CB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_data = '0;
  logic [CB-1:0] cmd_count = '0;
  logic          rsp_valid, rsp_ready = 1'b1, bus_wr, bus_rd, busy;
  logic [31:0]   rsp_data, bus_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;

  logic          b_valid = 1'b0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 1'b1, b_wr, b_rd, b_busy;
  logic [31:0]   b_rsp_data, b_wdata, b_rdata;
  logic [AW-1:0] b_addr;

  reg_bus_master #(.pADDRESS_BITS(AW), .pREAD_LATENCY(1), .pRSP_DEPTH(DEPTH), .pCOUNT_BITS(CB)) u_dut (
    .iCLOCK(clk), .iRESET(rst_n), .iCMD_VALID(cmd_valid), .oCMD_READY(cmd_ready),
    .iCMD_WRITE(cmd_write), .iCMD_ADDRESS(cmd_addr), .iCMD_DATA(cmd_data), .iCMD_COUNT(cmd_count),
    .oRSP_VALID(rsp_valid), .iRSP_READY(rsp_ready), .oRSP_DATA(rsp_data), .oADDRESS(bus_addr),
    .oWRITE(bus_wr), .oREAD(bus_rd), .oWRITE_DATA(bus_wdata), .iREAD_DATA(bus_rdata), .oBUSY(busy));

  reg_bus_master #(.pADDRESS_BITS(AW), .pREAD_LATENCY(3), .pRSP_DEPTH(DEPTH), .pCOUNT_BITS(CB)) u_dut3 (
    .iCLOCK(clk), .iRESET(rst_n), .iCMD_VALID(b_valid), .oCMD_READY(b_cmd_ready),
    .iCMD_WRITE(cmd_write), .iCMD_ADDRESS(cmd_addr), .iCMD_DATA(cmd_data), .iCMD_COUNT(cmd_count),
    .oRSP_VALID(b_rsp_valid), .iRSP_READY(b_rsp_ready), .oRSP_DATA(b_rsp_data), .oADDRESS(b_addr),
    .oWRITE(b_wr), .oREAD(b_rd), .oWRITE_DATA(b_wdata), .iREAD_DATA(b_rdata), .oBUSY(b_busy));

  // Slave: data for a strobe in cycle T is presented during cycle T+latency.
  logic [31:0]   slave_mem [8];
  logic [AW-1:0] sa_q = '0;
  logic [AW-1:0] sb_q [3];
  always @(posedge clk) begin
    sa_q    <= bus_addr;
    sb_q[0] <= b_addr;
    sb_q[1] <= sb_q[0];
    sb_q[2] <= sb_q[1];
  end
  assign bus_rdata = slave_mem[sa_q];
  assign b_rdata   = slave_mem[sb_q[2]];

  int n_cmp = 0, n_err = 0, n_rd = 0, n_wr = 0, n_rsp = 0;
  bit rand_ready = 1'b0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_ra[$];
  logic [AW-1:0] exp_wa[$];
  logic [31:0]   exp_wd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int beats(input logic wr, input logic [CB-1:0] cnt);
`ifdef REG_BUS_MASTER_BURST_EN
    if (wr) return 1;
    return (cnt == 0) ? 1 : int'(cnt);
`else
    return 1;
`endif
  endfunction

  // Scoreboard the current cycle, then advance to #1 after the next rising edge.
  task automatic cyc();
    chk("rd_wr_exclusive", 32'(bus_rd & bus_wr), 32'd0);
    if (bus_rd) begin
      n_rd++;
      chk("rd_expected", 32'(exp_ra.size() != 0), 32'd1);
      if (exp_ra.size() != 0) chk("rd_addr", 32'(bus_addr), 32'(exp_ra.pop_front()));
    end
    if (bus_wr) begin
      n_wr++;
      chk("wr_expected", 32'(exp_wa.size() != 0), 32'd1);
      if (exp_wa.size() != 0) begin
        chk("wr_addr", 32'(bus_addr), 32'(exp_wa.pop_front()));
        chk("wr_data", bus_wdata, exp_wd.pop_front());
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("rsp_data", rsp_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [CB-1:0] cnt);
    int guard = 0;
    while (!cmd_ready && guard < 200) begin
      cyc();
      guard++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_count = cnt;
    if (wr) begin
      exp_wa.push_back(a);
      exp_wd.push_back(d);
    end else begin
      for (int i = 0; i < beats(wr, cnt); i++) begin
        exp_ra.push_back(AW'((int'(a) + i) % (1 << AW)));
        exp_q.push_back(slave_mem[(int'(a) + i) % (1 << AW)]);
      end
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((busy || exp_q.size() != 0 || exp_ra.size() != 0 || exp_wa.size() != 0) && g < 300) begin
      cyc();
      g++;
    end
    chk("drain_in_time", 32'(g < 300), 32'd1);
  endtask

  initial begin
    int base_rd, base_rsp, nb, acc;
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) slave_mem[i] = $urandom;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_strobes", {30'd0, bus_wr, bus_rd}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Single write
    base_rsp = n_rsp;
    send(1'b1, 3'd3, 32'h0000_00F0, 8'd0);
    chk("w_strobe_c1", {30'd0, bus_wr, bus_rd}, 32'd2);
    chk("w_addr_c1", 32'(bus_addr), 32'd3);
    chk("w_data_c1", bus_wdata, 32'h0000_00F0);
    chk("w_ready_c1", 32'(cmd_ready), 32'd0);
    cyc();
    chk("w_strobe_c2", 32'(bus_wr), 32'd0);
    chk("w_data_hold", bus_wdata, 32'h0000_00F0);
    chk("w_ready_c2", 32'(cmd_ready), 32'd1);
    drain();
    chk("w_no_rsp", 32'(n_rsp - base_rsp), 32'd0);

    // Single read at latency 1 and 3 launched together
    slave_mem[5] = 32'hA5A5_0001;
    chk("b_ready_c0", 32'(b_cmd_ready), 32'd1);
    b_valid = 1'b1;
    send(1'b0, 3'd5, 32'd0, 8'd1);
    b_valid = 1'b0;
    chk("r_strobe_c1", {30'd0, bus_wr, bus_rd}, 32'd1);
    chk("r_addr_c1", 32'(bus_addr), 32'd5);
    chk("b_strobe_c1", {30'd0, b_wr, b_rd}, 32'd1);
    cyc();
    chk("r_rsp_c2", 32'(rsp_valid), 32'd0);
    cyc();
    chk("r_rsp_c3", 32'(rsp_valid), 32'd1);
    chk("r_data_c3", rsp_data, 32'hA5A5_0001);
    chk("b_rsp_c3", 32'(b_rsp_valid), 32'd0);
    cyc();
    chk("b_rsp_c4", 32'(b_rsp_valid), 32'd0);
    cyc();
    chk("b_rsp_c5", 32'(b_rsp_valid), 32'd1);
    chk("b_data_c5", b_rsp_data, 32'hA5A5_0001);
    drain();

    // Burst with address wrap
    for (int i = 0; i < 8; i++) slave_mem[i] = $urandom;
    base_rd = n_rd; base_rsp = n_rsp;
    nb = beats(1'b0, 8'd4);
    send(1'b0, 3'd6, 32'd0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nb) begin
        chk("burst_rd", 32'(bus_rd), 32'd1);
        chk("burst_addr", 32'(bus_addr), 32'((6 + i) % 8));
      end else begin
        chk("burst_tail_idle", 32'(bus_rd), 32'd0);
      end
      cyc();
    end
    drain();
    chk("burst_rd_count", 32'(n_rd - base_rd), 32'(nb));
    chk("burst_rsp_count", 32'(n_rsp - base_rsp), 32'(nb));

    // Backpressure on a long burst
    for (int i = 0; i < 8; i++) slave_mem[i] = $urandom;
    base_rd = n_rd; base_rsp = n_rsp;
    nb = beats(1'b0, 8'd6);
    rsp_ready = 1'b0;
    a = AW'($urandom);
    send(1'b0, a, 32'd0, 8'd6);
    repeat (12) cyc();
    chk("bp_stalled_reads", 32'(n_rd - base_rd), 32'((nb < DEPTH) ? nb : DEPTH));
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_no_strobe", 32'(bus_rd), 32'd0);
    rsp_ready = 1'b1;
    drain();
    chk("bp_rd_total", 32'(n_rd - base_rd), 32'(nb));
    chk("bp_rsp_total", 32'(n_rsp - base_rsp), 32'(nb));

    // Credit gates command acceptance when responses are not consumed
    rsp_ready = 1'b0;
    acc = 0;
    repeat (16) begin
      if (cmd_ready) begin
        send(1'b0, AW'($urandom), 32'd0, 8'd1);
        acc++;
      end else begin
        cyc();
      end
    end
    chk("credit_accepts", 32'(acc), 32'(DEPTH));
    chk("credit_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    drain();

    // Random commands with random response backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom), $urandom, CB'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) cyc();
    end
    drain();
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("rand_idle_busy", 32'(busy), 32'd0);

    // Reset during beat 2 of a burst
    send(1'b0, 3'd0, 32'd0, 8'd4);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'd0, bus_wr, bus_rd}, 32'd0);
    chk("mid_rst_addr", 32'(bus_addr), 32'd0);
    chk("mid_rst_wdata", bus_wdata, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    exp_q.delete(); exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base_rsp = n_rsp;
    cyc();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (10) cyc();
    chk("post_rst_no_stale", 32'(n_rsp - base_rsp), 32'd0);
    chk("post_rst_b_no_stale", 32'(b_rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
